// File: rtl/regfile_banked_if.sv
// Bus bundle for regfile_banked: write port, two read ports, shadow-bank commands and status.
// The decoder side drives the master modport and the register file implements the slave modport.
interface regfile_banked_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
);
  // No valid/ready handshake. Every rising edge executes exactly one command:
  //   - the write request w_flag/w_addr/w_data is sampled on that edge;
  //   - the command strobes save/restore are sampled on the same edge;
  //   - there is no busy state, so a new command may be issued on every cycle.
  // Read data is combinational from r_addr_a/r_addr_b.
  logic             w_flag;
  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] w_data;
  logic [AW-1:0]    r_addr_a;
  logic [WIDTH-1:0] r_data_a;
  logic [AW-1:0]    r_addr_b;
  logic [WIDTH-1:0] r_data_b;
  logic             save;
  logic             restore;
  logic             shadow_valid;
  logic             w_dropped;
  logic [1:0]       cmd_dbg;

  modport master (
    output w_flag, w_addr, w_data, r_addr_a, r_addr_b, save, restore,
    input  r_data_a, r_data_b, shadow_valid, w_dropped, cmd_dbg
  );

  modport slave (
    input  w_flag, w_addr, w_data, r_addr_a, r_addr_b, save, restore,
    output r_data_a, r_data_b, shadow_valid, w_dropped, cmd_dbg
  );
endinterface

// File: rtl/regfile_banked.sv
// Banked register file: DEPTH x WIDTH main bank with two forwarding read ports and one write port,
// plus a shadow bank that is saved, restored or swapped in a single edge.
module regfile_banked #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  regfile_banked_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    CMD_IDLE    = 2'd0,
    CMD_SAVE    = 2'd1,
    CMD_RESTORE = 2'd2,
    CMD_SWAP    = 2'd3
  } cmd_e;

  logic [WIDTH-1:0] main_q   [DEPTH];
  logic [WIDTH-1:0] shadow_q [DEPTH];
  logic [WIDTH-1:0] main_d   [DEPTH];
  logic [WIDTH-1:0] shadow_d [DEPTH];
  logic             shadow_valid_q;
  logic             shadow_valid_d;
  logic             w_dropped_q;
  logic             w_dropped_d;

  cmd_e             cmd;
  logic             discard;
  logic             wr_commit;
  logic [WIDTH-1:0] r_data_a;
  logic [WIDTH-1:0] r_data_b;

  // Effective command: restore without a saved context is a no-op, swap without one is a save.
  always_comb begin
    cmd = CMD_IDLE;
    case ({bus.save, bus.restore})
      2'b10:   cmd = CMD_SAVE;
      2'b01:   cmd = shadow_valid_q ? CMD_RESTORE : CMD_IDLE;
      2'b11:   cmd = shadow_valid_q ? CMD_SWAP : CMD_SAVE;
      default: cmd = CMD_IDLE;
    endcase
  end

  assign discard   = (cmd == CMD_RESTORE) || (cmd == CMD_SWAP);
  assign wr_commit = bus.w_flag && !discard && !(ZERO_REG && (bus.w_addr == '0));

  // Forwarding only reflects writes that really land; bank transfers are never forwarded.
  always_comb begin
    r_data_a = main_q[bus.r_addr_a];
    if (!reset_n || (ZERO_REG && (bus.r_addr_a == '0))) begin
      r_data_a = '0;
    end else if (wr_commit && (bus.w_addr == bus.r_addr_a)) begin
      r_data_a = bus.w_data;
    end
  end

  always_comb begin
    r_data_b = main_q[bus.r_addr_b];
    if (!reset_n || (ZERO_REG && (bus.r_addr_b == '0))) begin
      r_data_b = '0;
    end else if (wr_commit && (bus.w_addr == bus.r_addr_b)) begin
      r_data_b = bus.w_data;
    end
  end

  // Bank transfers use pre-edge contents of both banks; a save still lets the write land in main.
  always_comb begin
    main_d         = main_q;
    shadow_d       = shadow_q;
    shadow_valid_d = shadow_valid_q;
    case (cmd)
      CMD_SAVE: begin
        shadow_d       = main_q;
        shadow_valid_d = 1'b1;
      end
      CMD_RESTORE: begin
        main_d         = shadow_q;
        shadow_valid_d = 1'b0;
      end
      CMD_SWAP: begin
        main_d         = shadow_q;
        shadow_d       = main_q;
        shadow_valid_d = 1'b1;
      end
      default: ;
    endcase
    if (wr_commit) begin
      main_d[bus.w_addr] = bus.w_data;
    end
    if (ZERO_REG) begin
      main_d[0]   = '0;
      shadow_d[0] = '0;
    end
  end

  assign w_dropped_d = bus.w_flag && discard;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        main_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
      shadow_valid_q <= 1'b0;
      w_dropped_q    <= 1'b0;
    end else begin
      main_q         <= main_d;
      shadow_q       <= shadow_d;
      shadow_valid_q <= shadow_valid_d;
      w_dropped_q    <= w_dropped_d;
    end
  end

  assign bus.r_data_a     = r_data_a;
  assign bus.r_data_b     = r_data_b;
  assign bus.shadow_valid = shadow_valid_q;
  assign bus.w_dropped    = w_dropped_q;
  assign bus.cmd_dbg      = cmd;
endmodule

// File: tb/tb_regfile_banked.sv
// Self-checking bench for regfile_banked: directed steps followed by random traffic
// against an array-based model of the main bank, shadow bank and saved-context flag.
module tb_regfile_banked;
  localparam int W     = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam bit ZERO  = 1'b1;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  regfile_banked_if #(.WIDTH(W), .AW(AW)) bus ();

  regfile_banked #(.WIDTH(W), .DEPTH(DEPTH), .ZERO_REG(ZERO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Reference model
  logic [W-1:0] m_main   [DEPTH];
  logic [W-1:0] m_shadow [DEPTH];
  bit           m_valid;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_main[i]   = '0;
      m_shadow[i] = '0;
    end
    m_valid = 1'b0;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full clock cycle: drive at negedge, check reads before the edge, status after it.
  task automatic cycle(input string tag, input logic wf, input logic [AW-1:0] wa,
                       input logic [W-1:0] wd, input logic sv, input logic rs,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    logic [W-1:0] old_main [DEPTH];
    logic [W-1:0] old_shadow [DEPTH];
    logic [W-1:0] exp_a;
    logic [W-1:0] exp_b;
    bit disc;
    bit commit;
    bus.w_flag   = wf;
    bus.w_addr   = wa;
    bus.w_data   = wd;
    bus.save     = sv;
    bus.restore  = rs;
    bus.r_addr_a = ra;
    bus.r_addr_b = rb;
    disc   = rs && m_valid;
    commit = wf && !disc && !(ZERO && wa == 0);
    exp_a  = (ZERO && ra == 0) ? '0 : (commit && wa == ra) ? wd : m_main[ra];
    exp_b  = (ZERO && rb == 0) ? '0 : (commit && wa == rb) ? wd : m_main[rb];
    #2;
    check({tag, ".rd_a"}, bus.r_data_a, exp_a);
    check({tag, ".rd_b"}, bus.r_data_b, exp_b);
    old_main   = m_main;
    old_shadow = m_shadow;
    if (sv && !disc) begin
      m_shadow = old_main;
      m_valid  = 1'b1;
    end
    if (disc) begin
      m_main = old_shadow;
      if (sv) m_shadow = old_main;
      else    m_valid  = 1'b0;
    end
    if (commit) m_main[wa] = wd;
    @(posedge clk);
    #1;
    check({tag, ".shadow_valid"}, W'(bus.shadow_valid), W'(m_valid));
    check({tag, ".w_dropped"}, W'(bus.w_dropped), W'(wf && disc));
    @(negedge clk);
  endtask

  // Read a register with no write pending, against a literal value.
  task automatic peek(input string tag, input logic [AW-1:0] addr, input logic [W-1:0] exp);
    bus.w_flag   = 1'b0;
    bus.save     = 1'b0;
    bus.restore  = 1'b0;
    bus.r_addr_a = addr;
    #1;
    check(tag, bus.r_data_a, exp);
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.w_flag   = 1'b1;
    bus.w_addr   = 4'd3;
    bus.w_data   = 16'h5A5A;
    bus.save     = 1'b0;
    bus.restore  = 1'b0;
    bus.r_addr_a = 4'd3;
    bus.r_addr_b = 4'd7;
    model_reset();
    #2;
    check("reset.rd_a", bus.r_data_a, 16'h0000);
    check("reset.rd_b", bus.r_data_b, 16'h0000);
    check("reset.shadow_valid", W'(bus.shadow_valid), 16'h0000);
    check("reset.w_dropped", W'(bus.w_dropped), 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic writes and hold
    cycle("wr3a", 1, 4'd3, 16'hAA55, 0, 0, 4'd3, 4'd3);
    peek("r3_aa55", 4'd3, 16'hAA55);
    cycle("wr3b", 1, 4'd3, 16'hFF00, 0, 0, 4'd3, 4'd1);
    peek("r3_ff00", 4'd3, 16'hFF00);
    cycle("nowr3", 0, 4'd3, 16'hFFFF, 0, 0, 4'd3, 4'd3);
    peek("r3_hold", 4'd3, 16'hFF00);

    // Forwarding and zero register
    cycle("wr5", 1, 4'd5, 16'h1234, 0, 0, 4'd5, 4'd0);
    cycle("fwd5", 1, 4'd5, 16'hBEEF, 0, 0, 4'd5, 4'd5);
    peek("r5_beef", 4'd5, 16'hBEEF);
    cycle("wr0", 1, 4'd0, 16'hFFFF, 0, 0, 4'd0, 4'd0);
    peek("r0_zero", 4'd0, 16'h0000);

    // Save with write, then restore with dropped write
    cycle("wr1", 1, 4'd1, 16'h0011, 0, 0, 4'd1, 4'd2);
    cycle("save", 1, 4'd1, 16'h0022, 1, 0, 4'd1, 4'd2);
    peek("r1_after_save", 4'd1, 16'h0022);
    cycle("restore", 1, 4'd2, 16'h7777, 0, 1, 4'd2, 4'd1);
    peek("r1_restored", 4'd1, 16'h0011);
    peek("r2_untouched", 4'd2, 16'h0000);
    cycle("idle_after_restore", 0, 4'd2, 16'h0000, 0, 0, 4'd1, 4'd2);

    // Restore with no saved context lets the write through
    cycle("restore_novalid", 1, 4'd4, 16'h4444, 0, 1, 4'd4, 4'd4);
    peek("r4_4444", 4'd4, 16'h4444);

    // Swap
    cycle("wr6_9999", 1, 4'd6, 16'h9999, 0, 0, 4'd6, 4'd6);
    cycle("save6", 0, 4'd0, 16'h0000, 1, 0, 4'd6, 4'd6);
    cycle("wr6_6666", 1, 4'd6, 16'h6666, 0, 0, 4'd6, 4'd6);
    cycle("swap1", 1, 4'd6, 16'hDEAD, 1, 1, 4'd6, 4'd6);
    peek("r6_swapped", 4'd6, 16'h9999);
    cycle("swap2", 0, 4'd6, 16'h0000, 1, 1, 4'd6, 4'd6);
    peek("r6_swapped_back", 4'd6, 16'h6666);

    // Asynchronous reset between edges with a saved context
    bus.w_flag   = 1'b1;
    bus.w_addr   = 4'd7;
    bus.w_data   = 16'hABCD;
    bus.r_addr_a = 4'd7;
    bus.r_addr_b = 4'd6;
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_rst.rd_a", bus.r_data_a, 16'h0000);
    check("async_rst.rd_b", bus.r_data_b, 16'h0000);
    check("async_rst.shadow_valid", W'(bus.shadow_valid), 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    cycle("restore_after_rst", 0, 4'd0, 16'h0000, 0, 1, 4'd6, 4'd4);
    peek("r6_cleared", 4'd6, 16'h0000);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] wa, ra, rb;
      int sel;
      wa  = AW'($urandom_range(0, DEPTH - 1));
      ra  = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      rb  = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, DEPTH - 1));
      sel = $urandom_range(0, 7);
      cycle("rand", 1'($urandom_range(0, 1)), wa, W'($urandom),
            (sel == 0) || (sel == 2), (sel == 1) || (sel == 2), ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
